// File: rtl/hart_sched.sv
// hart_sched: round-robin fine-grained multithreading issue scheduler with per-hart PC table.
module hart_sched #(
    parameter int HART_NUM = 4,
    parameter int HART_ID_W = 2,
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 id_hkill,
    input  logic                 id_hstart,
    input  logic                 id_hidle,
    input  logic [HART_ID_W-1:0] id_set_hid,
    input  logic [HART_ID_W-1:0] id_hs_id,
    input  logic [PC_W-1:0]      id_hs_pc,
    input  logic                 br_taken,
    input  logic [HART_ID_W-1:0] br_hart_id,
    input  logic [PC_W-1:0]      br_addr,
    output logic                 if_en,
    output logic [HART_ID_W-1:0] if_hart_id,
    output logic [PC_W-1:0]      if_pc,
    output logic [HART_NUM-1:0]  hart_active,
    output logic                 kill_flush,
    output logic [HART_ID_W-1:0] kill_hid
);
    logic [HART_NUM-1:0]  act_q, act_d;
    logic [PC_W-1:0]      pc_q [HART_NUM];
    logic [PC_W-1:0]      pc_d [HART_NUM];
    logic [HART_ID_W-1:0] last_q, last_d, hid_q, hid_d, khid_q, khid_d, sel, idx;
    logic [PC_W-1:0]      ifpc_q, ifpc_d;
    logic                 en_q, en_d, kf_q, kf_d, found, kill, start, issue;

    assign kill  = ~stall & (id_hkill | id_hidle);
    assign start = ~stall & id_hstart & ~act_q[id_hs_id] & ~(kill & (id_set_hid == id_hs_id));
    assign issue = ~stall & found;

    // descending scan so the nearest hart after last_q wins
    always_comb begin
        found = 1'b0;
        sel = last_q;
        idx = last_q;
        for (int k = HART_NUM; k >= 1; k--) begin
            idx = last_q + HART_ID_W'(k);
            if (act_q[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end

    // redirect overrides the issue increment, start PC overrides both
    always_comb begin
        act_d = act_q;
        pc_d = pc_q;
        if (issue) pc_d[sel] = pc_q[sel] + PC_W'(4);
        if (br_taken) pc_d[br_hart_id] = br_addr;
        if (start) begin
            act_d[id_hs_id] = 1'b1;
            pc_d[id_hs_id] = id_hs_pc;
        end
        if (kill) act_d[id_set_hid] = 1'b0;
        en_d = stall ? en_q : found;
        hid_d = issue ? sel : hid_q;
        ifpc_d = issue ? pc_q[sel] : ifpc_q;
        last_d = issue ? sel : last_q;
        kf_d = kill & act_q[id_set_hid];
        khid_d = kf_d ? id_set_hid : khid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q <= HART_NUM'(1);
            for (int i = 0; i < HART_NUM; i++) pc_q[i] <= (i == 0) ? RESET_PC : '0;
            last_q <= HART_ID_W'(HART_NUM - 1);
            en_q <= 1'b0;
            hid_q <= '0;
            ifpc_q <= '0;
            kf_q <= 1'b0;
            khid_q <= '0;
        end else begin
            act_q <= act_d;
            pc_q <= pc_d;
            last_q <= last_d;
            en_q <= en_d;
            hid_q <= hid_d;
            ifpc_q <= ifpc_d;
            kf_q <= kf_d;
            khid_q <= khid_d;
        end
    end

    assign if_en = en_q;
    assign if_hart_id = hid_q;
    assign if_pc = ifpc_q;
    assign hart_active = act_q;
    assign kill_flush = kf_q;
    assign kill_hid = khid_q;
endmodule

// File: tb/tb_hart_sched.sv
// tb_hart_sched: randomized scoreboard bench for hart_sched against an array-based model.
module tb_hart_sched;
    logic        clk = 0, reset = 0, stall = 0, id_hkill = 0, id_hstart = 0, id_hidle = 0, br_taken = 0;
    logic [1:0]  id_set_hid = 0, id_hs_id = 0, br_hart_id = 0;
    logic [31:0] id_hs_pc = 0, br_addr = 0;
    logic        if_en, kill_flush;
    logic [1:0]  if_hart_id, kill_hid;
    logic [31:0] if_pc;
    logic [3:0]  hart_active;

    hart_sched dut (
        .clk(clk), .reset(reset), .stall(stall), .id_hkill(id_hkill), .id_hstart(id_hstart),
        .id_hidle(id_hidle), .id_set_hid(id_set_hid), .id_hs_id(id_hs_id), .id_hs_pc(id_hs_pc),
        .br_taken(br_taken), .br_hart_id(br_hart_id), .br_addr(br_addr), .if_en(if_en),
        .if_hart_id(if_hart_id), .if_pc(if_pc), .hart_active(hart_active),
        .kill_flush(kill_flush), .kill_hid(kill_hid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        en;
        bit [1:0]  hid;
        bit [31:0] pc;
        bit [3:0]  act;
        bit        kf;
        bit [1:0]  khid;
    } exp_t;

    exp_t q[$];
    int pass_n = 0, total_n = 0;

    bit [3:0]  m_act;
    bit [31:0] m_pc [4];
    int        m_last;
    bit        m_en, m_kf;
    bit [1:0]  m_hid, m_khid;
    bit [31:0] m_ifpc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_n++;
        if (got === want) pass_n++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("if_en", 32'(if_en), 32'(e.en));
            chk("if_hart_id", 32'(if_hart_id), 32'(e.hid));
            chk("if_pc", if_pc, e.pc);
            chk("hart_active", 32'(hart_active), 32'(e.act));
            chk("kill_flush", 32'(kill_flush), 32'(e.kf));
            if (e.kf) chk("kill_hid", 32'(kill_hid), 32'(e.khid));
        end
    end

    task automatic cyc(input bit rs, st, hk, hs, hi, input int sid, hsid, input bit [31:0] hspc,
                       input bit br, input int bh, input bit [31:0] ba);
        int h;
        bit kill;
        bit [3:0] na;
        bit [31:0] np [4];
        exp_t e;
        @(negedge clk);
        reset = rs; stall = st; id_hkill = hk; id_hstart = hs; id_hidle = hi;
        id_set_hid = 2'(sid); id_hs_id = 2'(hsid); id_hs_pc = hspc;
        br_taken = br; br_hart_id = 2'(bh); br_addr = ba;
        if (rs) begin
            m_act = 4'b0001;
            for (int i = 0; i < 4; i++) m_pc[i] = 0;
            m_last = 3; m_en = 0; m_hid = 0; m_ifpc = 0; m_kf = 0; m_khid = 0;
        end else begin
            h = -1;
            for (int k = 1; k <= 4; k++) if (h < 0 && m_act[(m_last + k) % 4]) h = (m_last + k) % 4;
            na = m_act;
            np = m_pc;
            m_kf = 0;
            if (!st) begin
                if (h >= 0) begin
                    m_en = 1; m_hid = 2'(h); m_ifpc = m_pc[h]; np[h] = m_pc[h] + 4; m_last = h;
                end else m_en = 0;
            end
            if (br) np[bh] = ba;
            if (!st) begin
                kill = hk | hi;
                if (hs && !m_act[hsid] && !(kill && sid == hsid)) begin
                    na[hsid] = 1; np[hsid] = hspc;
                end
                if (kill) begin
                    if (m_act[sid]) begin m_kf = 1; m_khid = 2'(sid); end
                    na[sid] = 0;
                end
            end
            m_act = na;
            m_pc = np;
        end
        e.en = m_en; e.hid = m_hid; e.pc = m_ifpc; e.act = m_act; e.kf = m_kf; e.khid = m_khid;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        cyc(0, 0, 0, 1, 0, 0, 2, 32'h100, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h200, 0, 0, 0);
        idle(6);
        cyc(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0, 3, 32'h400, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
        idle(3);
        cyc(0, 0, 1, 1, 0, 2, 2, 32'h300, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 1, 0, 0, 2, 32'h300, 1, 2, 32'h500);
        idle(2);
        cyc(0, 0, 0, 1, 1, 2, 2, 32'h600, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1, 0, 0, 3, 32'hFFFF_FFFC, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 3000; i++)
            cyc($urandom % 300 == 0, $urandom % 5 == 0, $urandom % 9 == 0, $urandom % 3 == 0,
                $urandom % 11 == 0, int'($urandom % 4), int'($urandom % 4), $urandom & 32'hFFFF_FFFC,
                $urandom % 6 == 0, int'($urandom % 4), $urandom & 32'hFFFF_FFFC);
        idle(1);
        repeat (2) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total_n++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
